countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Counterpart to the stopwatch: counts a user preset down to zero in hundredths of a second, then raises an alarm.
- Shares the stopwatch's BCD digit output format, so the existing display path consumes it unchanged.
- Runs on the single system clock; hundredths are paced by a one-cycle 100 Hz tick enable from the clock divider.
- Selected by the same SPDT mode-enable scheme.

Parameters:
- ALARM_TICKS, 200, number of 100 Hz ticks ALARM stays high after expiry (2 s).
- CNT_W, 8, width of the alarm duration counter; must hold ALARM_TICKS.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RESET  input  1  synchronous, active-low reset.
- TICK_100HZ  input  1  one-CLK-cycle pulse every 10 ms.
- ENABLE  input  1  SPDT timer-mode select; low forces IDLE.
- START_STOP  input  1  debounced level from a button; rising edge is the command.
- LOAD  input  1  level; sampled each cycle, copies the SET_* digits into the preset.
- SET_SEC_10, SET_SEC_01, SET_MSEC_10, SET_MSEC_01  input  4 each  BCD preset digits.
- SEC_10, SEC_01, MSEC_10, MSEC_01  output  4 each  current remaining time in BCD.
- RUNNING  output  1  high in RUN state.
- ALARM  output  1  high while the alarm is sounding.

Behaviour:
- Reset (RESET==0 at a CLK edge):
  - state=IDLE; all digits=0; preset=00.00; prev_btn=0; ALARM=0; RUNNING=0; alarm counter=0.
- Edge detect: start_edge = START_STOP & ~prev_btn. prev_btn updates every cycle when ENABLE is high and is cleared when ENABLE is low.
- ENABLE low: same clearing as reset on the next edge. It has priority over every other input except RESET.
- Preset capture:
  - Each SET_* digit above 9 is clamped to 9 on capture.
  - LOAD is accepted in IDLE, PAUSED and EXPIRED. Effects: preset<=clamped SET_*, display digits<=clamped SET_*, ALARM<=0, next state PAUSED.
  - LOAD is ignored in RUN.
- States:
  - IDLE: display 00.00. start_edge is ignored, with no transition.
  - PAUSED: display holds its value. On start_edge, go to RUN if the display is nonzero; at 00.00 the edge is ignored.
  - RUN: on each TICK_100HZ, decrement the 4-digit BCD value by 0.01 with digit borrow (MSEC_01 0->9 borrows from MSEC_10, and so on up to SEC_10).
    - start_edge -> PAUSED.
    - A tick that produces 00.00 -> EXPIRED in the same edge.
  - EXPIRED: display 00.00.
    - ALARM=1 from the cycle after entry until ALARM_TICKS ticks have elapsed, then 0.
    - start_edge: ALARM<=0, digits<=preset, go to PAUSED.
- Latency:
  - Commands take effect on the CLK edge where they are sampled; outputs are registered, so they change one cycle after the input.
  - The first decrement after start occurs on the first tick strictly after the RUN transition.
- Simultaneous events:
  - start_edge and tick in the same cycle: the edge wins. PAUSED->RUN applies no decrement; RUN->PAUSED drops that tick.
  - LOAD and start_edge in the same cycle: LOAD wins and the edge is consumed.
- Underflow: no decrement below 00.00 under any condition.
- Digit validity: outputs are always valid BCD (0-9).

Decomposition:
- Shared package timer_pkg:
  - state enum {IDLE, PAUSED, RUN, EXPIRED} as 2-bit localparams.
  - BCD_W=4 and BCD_MAX=9 constants.
  - Clamp function for BCD digits.
- Sub-module bcd_down_digit, instantiated 4x:
  - Inputs: dec_en, load, load_val.
  - Outputs: digit and borrow_out. borrow_out = dec_en & (digit==0), and the digit wraps to 9.
- Top level: the FSM, the zero-detect across all four digits, edge detect, and the alarm counter.

Test Plan:
- Reset and ENABLE: RESET=0 for 2 cycles with arbitrary inputs -> digits 00.00, RUNNING=0, ALARM=0. ENABLE=0 mid-RUN -> IDLE and 00.00 next cycle.
- Load and clamp: LOAD with SET=1,F,0,5 -> display 19.05, state PAUSED. A start_edge in IDLE beforehand -> no change.
- Borrow chain: preset 10.00, start, 1 tick -> 09.99. 100 more ticks -> 08.99. Ticks in PAUSED -> no change.
- Expiry and alarm: preset 00.03, start, 3 ticks -> 00.00, RUNNING=0. ALARM=1 the next cycle for exactly 200 ticks. A 4th tick leaves the display at 00.00.
- Simultaneity: start_edge coincident with a tick in PAUSED at 00.50 -> still 00.50 after that cycle. LOAD with a coincident start_edge -> PAUSED, no RUN.
- Restart: in EXPIRED with preset 00.50, start_edge -> ALARM=0, display 00.50, PAUSED. Start at 00.00 -> ignored.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer.
// Holds the FSM state encoding, BCD digit constants and the digit clamp
// used when the preset is captured from the setting switches.
package timer_pkg;

    localparam int              BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAUSED  = 2'd1,
        RUN     = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    // Setting switches can present 10..15; anything above 9 becomes 9.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of a down-counter.
// Ports:
//   CLK, RESET  clock, synchronous active-low reset (digit -> 0)
//   dec_en      decrement this digit on the clock edge
//   load        load load_val (takes priority over dec_en)
//   load_val    value to load
//   digit       current digit, always 0..9
//   borrow_out  dec_en while the digit is 0: the next digit up must decrement
module bcd_down_digit
    import timer_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             dec_en,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    output logic [BCD_W-1:0] digit,
    output logic             borrow_out
);

    assign borrow_out = dec_en & (digit == '0);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            digit <= '0;
        end else if (load) begin
            digit <= load_val;
        end else if (dec_en) begin
            digit <= (digit == '0) ? BCD_MAX : digit - 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: counts a BCD preset (SS.hh) down to 00.00 in hundredths
// of a second, then sounds ALARM for ALARM_TICKS ticks of the 100 Hz enable.
// Ports:
//   CLK, RESET        system clock, synchronous active-low reset
//   TICK_100HZ        one-cycle pulse every 10 ms
//   ENABLE            timer mode select; low clears everything to IDLE
//   START_STOP        debounced button level; its rising edge is the command
//   LOAD              level; copies clamped SET_* into preset and display
//   SET_*             BCD preset digits
//   SEC_10..MSEC_01   remaining time in BCD
//   RUNNING           high in RUN
//   ALARM             high while the alarm sounds
//   STATE_DBG         current FSM state, for observation only
//
// Command handshake: commands are sampled on the CLK edge; priority is
// RESET > ENABLE low > LOAD (outside RUN) > start edge > tick.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int ALARM_TICKS = 200,
    parameter int CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             TICK_100HZ,
    input  logic             ENABLE,
    input  logic             START_STOP,
    input  logic             LOAD,
    input  logic [BCD_W-1:0] SET_SEC_10,
    input  logic [BCD_W-1:0] SET_SEC_01,
    input  logic [BCD_W-1:0] SET_MSEC_10,
    input  logic [BCD_W-1:0] SET_MSEC_01,
    output logic [BCD_W-1:0] SEC_10,
    output logic [BCD_W-1:0] SEC_01,
    output logic [BCD_W-1:0] MSEC_10,
    output logic [BCD_W-1:0] MSEC_01,
    output logic             RUNNING,
    output logic             ALARM,
    output state_t           STATE_DBG
);

    localparam logic [CNT_W-1:0] ALARM_LIM = CNT_W'(ALARM_TICKS);

    state_t             state, state_next;
    logic [4*BCD_W-1:0] preset, preset_next;
    logic [4*BCD_W-1:0] disp;
    logic [4*BCD_W-1:0] set_clamped;
    logic [4*BCD_W-1:0] load_vec;
    logic [CNT_W-1:0]   alarm_cnt, cnt_next;
    logic               alarm, alarm_next;
    logic               prev_btn, prev_btn_next;
    logic               start_edge, is_zero, is_one;
    logic               dig_load, dec;
    logic [2:0]         borrow;
    logic               borrow_unused;

    assign start_edge  = START_STOP & ~prev_btn;
    assign is_zero     = (disp == '0);
    assign is_one      = (disp == 16'h0001);
    assign set_clamped = {bcd_clamp(SET_SEC_10), bcd_clamp(SET_SEC_01),
                          bcd_clamp(SET_MSEC_10), bcd_clamp(SET_MSEC_01)};

    // Digit chain, least significant first; each borrow feeds the next digit.
    bcd_down_digit u_msec_01 (.CLK(CLK), .RESET(RESET), .dec_en(dec),
        .load(dig_load), .load_val(load_vec[3:0]),
        .digit(disp[3:0]), .borrow_out(borrow[0]));
    bcd_down_digit u_msec_10 (.CLK(CLK), .RESET(RESET), .dec_en(borrow[0]),
        .load(dig_load), .load_val(load_vec[7:4]),
        .digit(disp[7:4]), .borrow_out(borrow[1]));
    bcd_down_digit u_sec_01 (.CLK(CLK), .RESET(RESET), .dec_en(borrow[1]),
        .load(dig_load), .load_val(load_vec[11:8]),
        .digit(disp[11:8]), .borrow_out(borrow[2]));
    // Top borrow never fires: decrement is blocked at 00.00.
    bcd_down_digit u_sec_10 (.CLK(CLK), .RESET(RESET), .dec_en(borrow[2]),
        .load(dig_load), .load_val(load_vec[15:12]),
        .digit(disp[15:12]), .borrow_out(borrow_unused));

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= IDLE;
            preset    <= '0;
            alarm_cnt <= '0;
            alarm     <= 1'b0;
            prev_btn  <= 1'b0;
        end else begin
            state     <= state_next;
            preset    <= preset_next;
            alarm_cnt <= cnt_next;
            alarm     <= alarm_next;
            prev_btn  <= prev_btn_next;
        end
    end

    always_comb begin
        state_next    = state;
        preset_next   = preset;
        cnt_next      = alarm_cnt;
        alarm_next    = alarm;
        prev_btn_next = START_STOP;
        dig_load      = 1'b0;
        load_vec      = '0;
        dec           = 1'b0;

        if (!ENABLE) begin
            state_next    = IDLE;
            preset_next   = '0;
            cnt_next      = '0;
            alarm_next    = 1'b0;
            prev_btn_next = 1'b0;
            dig_load      = 1'b1;
        end else if (LOAD && state != RUN) begin
            // LOAD consumes any coincident start edge.
            state_next  = PAUSED;
            preset_next = set_clamped;
            cnt_next    = '0;
            alarm_next  = 1'b0;
            dig_load    = 1'b1;
            load_vec    = set_clamped;
        end else begin
            case (state)
                IDLE: ;
                PAUSED: begin
                    if (start_edge && !is_zero) state_next = RUN;
                end
                RUN: begin
                    if (start_edge) begin
                        state_next = PAUSED;
                    end else if (TICK_100HZ && !is_zero) begin
                        dec = 1'b1;
                        if (is_one) begin
                            state_next = EXPIRED;
                            cnt_next   = '0;
                            alarm_next = 1'b0;
                        end
                    end
                end
                EXPIRED: begin
                    if (start_edge) begin
                        state_next = PAUSED;
                        cnt_next   = '0;
                        alarm_next = 1'b0;
                        dig_load   = 1'b1;
                        load_vec   = preset;
                    end else begin
                        // Alarm rises the cycle after entry and holds until
                        // ALARM_TICKS ticks have been counted.
                        if (TICK_100HZ && alarm_cnt != ALARM_LIM)
                            cnt_next = alarm_cnt + 1'b1;
                        alarm_next = (cnt_next != ALARM_LIM);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign {SEC_10, SEC_01, MSEC_10, MSEC_01} = disp;
    assign RUNNING   = (state == RUN);
    assign ALARM     = alarm;
    assign STATE_DBG = state;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;
    import timer_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       enable = 1'b1;
    logic       start_stop = 1'b0;
    logic       load = 1'b0;
    logic [3:0] set_sec_10 = '0, set_sec_01 = '0, set_msec_10 = '0, set_msec_01 = '0;
    logic [3:0] sec_10, sec_01, msec_10, msec_01;
    logic       running, alarm;
    state_t     st;
    logic [15:0] disp;

    int n_vec = 0;
    int n_err = 0;

    assign disp = {sec_10, sec_01, msec_10, msec_01};

    countdown_timer dut (
        .CLK(clk), .RESET(reset), .TICK_100HZ(tick), .ENABLE(enable),
        .START_STOP(start_stop), .LOAD(load),
        .SET_SEC_10(set_sec_10), .SET_SEC_01(set_sec_01),
        .SET_MSEC_10(set_msec_10), .SET_MSEC_01(set_msec_01),
        .SEC_10(sec_10), .SEC_01(sec_01), .MSEC_10(msec_10), .MSEC_01(msec_01),
        .RUNNING(running), .ALARM(alarm), .STATE_DBG(st)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1 ns after the rising edge, outputs are
    // observed at the same point, away from the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; cycle();
            tick = 1'b0; cycle();
        end
    endtask

    task automatic press_start();
        start_stop = 1'b1; cycle();
        start_stop = 1'b0; cycle();
    endtask

    task automatic do_load(input logic [15:0] v);
        {set_sec_10, set_sec_01, set_msec_10, set_msec_01} = v;
        load = 1'b1; cycle();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; load = 1'b1; start_stop = 1'b1; tick = 1'b1;
        {set_sec_10, set_sec_01, set_msec_10, set_msec_01} = 16'h7342;
        cycle(); cycle();
        reset = 1'b1; load = 1'b0; start_stop = 1'b0; tick = 1'b0;
        n_vec++; if (disp !== 16'h0000) begin n_err++; $display("FAIL reset_disp got %h want %h", disp, 16'h0000); end
        n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL reset_running got %b want 0", running); end
        n_vec++; if (alarm !== 1'b0) begin n_err++; $display("FAIL reset_alarm got %b want 0", alarm); end
        n_vec++; if (st !== IDLE) begin n_err++; $display("FAIL reset_state got %0d want %0d", st, IDLE); end
    endtask

    task automatic test_load_clamp();
        press_start();
        n_vec++; if (st !== IDLE) begin n_err++; $display("FAIL idle_start_state got %0d want %0d", st, IDLE); end
        n_vec++; if (disp !== 16'h0000) begin n_err++; $display("FAIL idle_start_disp got %h want %h", disp, 16'h0000); end
        do_load(16'h1F05);
        n_vec++; if (disp !== 16'h1905) begin n_err++; $display("FAIL load_clamp_disp got %h want %h", disp, 16'h1905); end
        n_vec++; if (st !== PAUSED) begin n_err++; $display("FAIL load_clamp_state got %0d want %0d", st, PAUSED); end
    endtask

    task automatic test_borrow();
        do_load(16'h1000);
        tick_n(3);
        n_vec++; if (disp !== 16'h1000) begin n_err++; $display("FAIL paused_tick_disp got %h want %h", disp, 16'h1000); end
        start_stop = 1'b1; cycle();
        n_vec++; if (running !== 1'b1) begin n_err++; $display("FAIL start_running got %b want 1", running); end
        start_stop = 1'b0; cycle();
        tick_n(1);
        n_vec++; if (disp !== 16'h0999) begin n_err++; $display("FAIL borrow_chain got %h want %h", disp, 16'h0999); end
        tick_n(100);
        n_vec++; if (disp !== 16'h0899) begin n_err++; $display("FAIL borrow_100 got %h want %h", disp, 16'h0899); end
        press_start();
        tick_n(5);
        n_vec++; if (st !== PAUSED) begin n_err++; $display("FAIL pause_state got %0d want %0d", st, PAUSED); end
        n_vec++; if (disp !== 16'h0899) begin n_err++; $display("FAIL pause_hold got %h want %h", disp, 16'h0899); end
    endtask

    task automatic test_enable();
        do_load(16'h1000);
        press_start();
        tick_n(2);
        n_vec++; if (disp !== 16'h0998) begin n_err++; $display("FAIL en_run_disp got %h want %h", disp, 16'h0998); end
        enable = 1'b0; cycle();
        n_vec++; if (st !== IDLE) begin n_err++; $display("FAIL en_low_state got %0d want %0d", st, IDLE); end
        n_vec++; if (disp !== 16'h0000) begin n_err++; $display("FAIL en_low_disp got %h want %h", disp, 16'h0000); end
        n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL en_low_running got %b want 0", running); end
        enable = 1'b1; cycle();
    endtask

    task automatic test_simultaneous();
        do_load(16'h0050);
        start_stop = 1'b1; tick = 1'b1; cycle();
        start_stop = 1'b0; tick = 1'b0;
        n_vec++; if (st !== RUN) begin n_err++; $display("FAIL sim_start_state got %0d want %0d", st, RUN); end
        n_vec++; if (disp !== 16'h0050) begin n_err++; $display("FAIL sim_start_disp got %h want %h", disp, 16'h0050); end
        cycle();
        start_stop = 1'b1; tick = 1'b1; cycle();
        start_stop = 1'b0; tick = 1'b0;
        n_vec++; if (st !== PAUSED) begin n_err++; $display("FAIL sim_stop_state got %0d want %0d", st, PAUSED); end
        n_vec++; if (disp !== 16'h0050) begin n_err++; $display("FAIL sim_stop_disp got %h want %h", disp, 16'h0050); end
        cycle();
        {set_sec_10, set_sec_01, set_msec_10, set_msec_01} = 16'h0123;
        load = 1'b1; start_stop = 1'b1; cycle();
        load = 1'b0; cycle();
        start_stop = 1'b0;
        n_vec++; if (st !== PAUSED) begin n_err++; $display("FAIL load_start_state got %0d want %0d", st, PAUSED); end
        n_vec++; if (disp !== 16'h0123) begin n_err++; $display("FAIL load_start_disp got %h want %h", disp, 16'h0123); end
    endtask

    task automatic test_expiry();
        do_load(16'h0003);
        press_start();
        tick_n(2);
        n_vec++; if (disp !== 16'h0001) begin n_err++; $display("FAIL exp_pre_disp got %h want %h", disp, 16'h0001); end
        tick = 1'b1; cycle(); tick = 1'b0;
        n_vec++; if (disp !== 16'h0000) begin n_err++; $display("FAIL exp_disp got %h want %h", disp, 16'h0000); end
        n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL exp_running got %b want 0", running); end
        n_vec++; if (alarm !== 1'b0) begin n_err++; $display("FAIL exp_alarm_entry got %b want 0", alarm); end
        n_vec++; if (st !== EXPIRED) begin n_err++; $display("FAIL exp_state got %0d want %0d", st, EXPIRED); end
        cycle();
        n_vec++; if (alarm !== 1'b1) begin n_err++; $display("FAIL alarm_rise got %b want 1", alarm); end
        tick_n(199);
        n_vec++; if (alarm !== 1'b1) begin n_err++; $display("FAIL alarm_199 got %b want 1", alarm); end
        n_vec++; if (disp !== 16'h0000) begin n_err++; $display("FAIL underflow_disp got %h want %h", disp, 16'h0000); end
        tick = 1'b1; cycle(); tick = 1'b0;
        n_vec++; if (alarm !== 1'b0) begin n_err++; $display("FAIL alarm_200 got %b want 0", alarm); end
        tick_n(3);
        n_vec++; if (alarm !== 1'b0) begin n_err++; $display("FAIL alarm_stays_off got %b want 0", alarm); end
    endtask

    task automatic test_restart();
        do_load(16'h0050);
        press_start();
        tick_n(50);
        n_vec++; if (st !== EXPIRED) begin n_err++; $display("FAIL rs_expired got %0d want %0d", st, EXPIRED); end
        cycle();
        n_vec++; if (alarm !== 1'b1) begin n_err++; $display("FAIL rs_alarm got %b want 1", alarm); end
        start_stop = 1'b1; cycle();
        n_vec++; if (alarm !== 1'b0) begin n_err++; $display("FAIL rs_alarm_clr got %b want 0", alarm); end
        n_vec++; if (disp !== 16'h0050) begin n_err++; $display("FAIL rs_disp got %h want %h", disp, 16'h0050); end
        n_vec++; if (st !== PAUSED) begin n_err++; $display("FAIL rs_state got %0d want %0d", st, PAUSED); end
        start_stop = 1'b0; cycle();
        do_load(16'h0000);
        press_start();
        n_vec++; if (st !== PAUSED) begin n_err++; $display("FAIL zero_start_state got %0d want %0d", st, PAUSED); end
        n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL zero_start_running got %b want 0", running); end
    endtask

    initial begin
        test_reset();
        test_load_clamp();
        test_borrow();
        test_enable();
        test_simultaneous();
        test_expiry();
        test_restart();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
